// File: rtl/cycle_ctrl_if.sv
// Data-memory handshake between the instruction sequencer and the data memory.
// The master (cycle_ctrl) raises mem_req/mem_wr; the slave answers with mem_ready.
interface cycle_ctrl_if;
   logic mem_req;
   logic mem_wr;
   logic mem_ready;

   modport master (output mem_req, output mem_wr, input mem_ready);
   modport slave  (input mem_req, input mem_wr, output mem_ready);
endinterface

// File: rtl/cycle_ctrl.sv
// cycle_ctrl: multi-cycle instruction sequencer. Gates PC write, IR load,
// register-file write and the data-memory handshake (watchdog-guarded).
// Optional feature macro: CYCLE_CTRL_PERF_EN builds the retired-instruction
// counter; without it, retired is tied to 0.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for run or a step pulse
// IF    | load instruction register
// ID    | decode; HLT goes straight to HALT
// EX    | execute; branch/jump retire here
// MEM   | data-memory request, watchdog running; SW retires on ready
// WB    | register write-back and retire
// HALT  | parked with every enable low; only reset leaves
module cycle_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rstd,
   input  logic        run,
   input  logic        step,
   input  logic        halt_req,
   input  logic [5:0]  opcode,
   cycle_ctrl_if.master mem,
   output logic        ir_we,
   output logic        pc_we,
   output logic        reg_we,
   output logic [2:0]  state,
   output logic        bus_err,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_HALT = 3'd6
   } st_t;

   // Watchdog fires on the MEM cycle in which the count would reach TIMEOUT.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   st_t        cur_st;
   st_t        nxt_st;
   st_t        bnd_st;
   logic [7:0] wdog;
   logic       set_err;

   logic is_lw;
   logic is_sw;
   logic is_br;
   logic is_hlt;

   // Opcode class decode.
   always_comb begin
      is_lw  = (opcode == 6'h23);
      is_sw  = (opcode == 6'h2B);
      is_br  = (opcode == 6'h04) || (opcode == 6'h05) ||
               (opcode == 6'h02) || (opcode == 6'h03);
      is_hlt = (opcode == 6'h3F);
   end

   // Next state at an instruction boundary: halt wins over run.
   always_comb begin
      bnd_st = S_IDLE;
      if (halt_req)
         bnd_st = S_HALT;
      else if (run)
         bnd_st = S_IF;
   end

   // State register.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd)
         cur_st <= S_IDLE;
      else
         cur_st <= nxt_st;
   end

   // Next-state and enable decode; enables depend on state, plus mem_ready in MEM.
   always_comb begin
      nxt_st      = cur_st;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      reg_we      = 1'b0;
      mem.mem_req = 1'b0;
      mem.mem_wr  = 1'b0;
      set_err     = 1'b0;
      case (cur_st)
         S_IDLE: begin
            if (run || step)
               nxt_st = S_IF;
         end
         S_IF: begin
            ir_we  = 1'b1;
            nxt_st = S_ID;
         end
         S_ID: begin
            nxt_st = is_hlt ? S_HALT : S_EX;
         end
         S_EX: begin
            if (is_lw || is_sw) begin
               nxt_st = S_MEM;
            end else if (is_br) begin
               pc_we  = 1'b1;
               nxt_st = bnd_st;
            end else begin
               nxt_st = S_WB;
            end
         end
         S_MEM: begin
            mem.mem_req = 1'b1;
            mem.mem_wr  = is_sw;
            if (mem.mem_ready) begin
               if (is_sw) begin
                  pc_we  = 1'b1;
                  nxt_st = bnd_st;
               end else begin
                  nxt_st = S_WB;
               end
            end else if (wdog == WD_LAST) begin
               set_err = 1'b1;
               nxt_st  = S_HALT;
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            pc_we  = 1'b1;
            nxt_st = bnd_st;
         end
         S_HALT: begin
            nxt_st = S_HALT;
         end
         default: begin
            nxt_st = S_IDLE;
         end
      endcase
   end

   // Watchdog: held at zero outside MEM, counts MEM cycles without ready.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd)
         wdog <= 8'd0;
      else if (cur_st != S_MEM)
         wdog <= 8'd0;
      else if (!mem.mem_ready)
         wdog <= wdog + 8'd1;
   end

   // Sticky bus error, cleared only by reset.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd)
         bus_err <= 1'b0;
      else if (set_err)
         bus_err <= 1'b1;
   end

   assign state = cur_st;

`ifdef CYCLE_CTRL_PERF_EN
   logic [31:0] ret_cnt;

   // Retired count: one per pc_we, wraps naturally.
   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd)
         ret_cnt <= 32'd0;
      else if (pc_we)
         ret_cnt <= ret_cnt + 32'd1;
   end

   assign retired = ret_cnt;
`else
   assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_cycle_ctrl.sv
// Scoreboard bench for cycle_ctrl: the driver pushes the expected retirement
// of each issued instruction; a negedge monitor pops on every pc_we.
module tb_cycle_ctrl;
   localparam int TO = 4;
`ifdef CYCLE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstd = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        halt_req = 1'b0;
   logic [5:0]  opcode = 6'h00;
   logic        ir_we;
   logic        pc_we;
   logic        reg_we;
   logic [2:0]  state;
   logic        bus_err;
   logic [31:0] retired;

   cycle_ctrl_if bus();

   cycle_ctrl #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .rstd     (rstd),
      .run      (run),
      .step     (step),
      .halt_req (halt_req),
      .opcode   (opcode),
      .mem      (bus),
      .ir_we    (ir_we),
      .pc_we    (pc_we),
      .reg_we   (reg_we),
      .state    (state),
      .bus_err  (bus_err),
      .retired  (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cpi;
      logic        wb;
      logic        st;
      logic [31:0] ret;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          if_cyc = 0;
   int          n_if = 0;
   int          n_pc = 0;
   int          cur_wait = 0;
   int          mcnt = 0;
   logic [31:0] model_ret = 32'd0;
   logic        chk_ret = 1'b0;
   logic [31:0] ret_exp = 32'd0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: cycles from IF to retirement, by opcode class.
   function automatic int cpi_of(logic [5:0] op, int w);
      if (op == 6'h23) return 5 + w;
      if (op == 6'h2B) return 4 + w;
      if (op inside {6'h02, 6'h03, 6'h04, 6'h05}) return 3;
      return 4;
   endfunction

   function automatic logic [31:0] ret_view(logic [31:0] n);
      return PERF ? n : 32'd0;
   endfunction

   task automatic expect_instr(logic [5:0] op, int w);
      exp_t x;
      model_ret++;
      x.cpi = cpi_of(op, w);
      x.wb  = !(op inside {6'h2B, 6'h02, 6'h03, 6'h04, 6'h05});
      x.st  = (op == 6'h2B);
      x.ret = model_ret;
      sb.push_back(x);
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] alu [8];
      int c;
      alu = '{6'h00, 6'h01, 6'h08, 6'h0C, 6'h10, 6'h22, 6'h2C, 6'h3E};
      c = $urandom_range(0, 4);
      case (c)
         0: return alu[$urandom_range(0, 7)];
         1: return 6'h23;
         2: return 6'h2B;
         3: return ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
         default: return ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03;
      endcase
   endfunction

   task automatic wait_ir(string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (ir_we) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: ir_we not seen within 30 cycles", name);
      end
   endtask

   task automatic wait_state(logic [2:0] tgt, int budget, string name);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (state == tgt) break;
      end
      check(name, state, tgt);
   endtask

   task automatic do_reset();
      rstd = 1'b0;
      sb.delete();
      model_ret = 32'd0;
      repeat (2) @(posedge clk);
      #3 rstd = 1'b1;
   endtask

   always @(posedge clk) cyc++;

   // Memory responder: ready after cur_wait wait cycles; noise outside MEM.
   always @(posedge clk) begin
      #1;
      if (bus.mem_req) begin
         bus.mem_ready = (mcnt == cur_wait);
         mcnt++;
      end else begin
         mcnt = 0;
         bus.mem_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops the scoreboard on every pc_we.
   always @(negedge clk) begin
      if (!rstd) begin
         chk_ret = 1'b0;
      end else begin
         if (chk_ret) begin
            check("retired", retired, ret_exp);
            chk_ret = 1'b0;
         end
         if (ir_we) begin
            if_cyc = cyc;
            n_if++;
         end
         if (bus.mem_req && sb.size() > 0)
            check("mem_wr", 32'(bus.mem_wr), 32'(sb[0].st));
         if (pc_we) begin
            n_pc++;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pc_we: unexpected pulse at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               check("cpi", 32'(cyc - if_cyc + 1), 32'(e.cpi));
               check("reg_we", 32'(reg_we), 32'(e.wb));
               ret_exp = ret_view(e.ret);
               chk_ret = 1'b1;
            end
         end else if (reg_we) begin
            n_checks++;
            n_fail++;
            $display("FAIL reg_we: high without pc_we at cycle %0d", cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] op;
      int         w;
      int         base;
      int         cnt;

      // Reset state
      #12;
      check("rst state", state, 3'd0);
      check("rst ir_we", ir_we, 1'b0);
      check("rst pc_we", pc_we, 1'b0);
      check("rst reg_we", reg_we, 1'b0);
      check("rst mem_req", bus.mem_req, 1'b0);
      check("rst bus_err", bus_err, 1'b0);
      check("rst retired", retired, 32'd0);
      @(negedge clk);
      rstd = 1'b1;

      // Random program under continuous run
      run = 1'b1;
      for (int i = 0; i < 40; i++) begin
         op = pick_op();
         w  = $urandom_range(0, TO - 1);
         wait_ir("run ir_we");
         @(posedge clk);
         #1;
         opcode   = op;
         cur_wait = w;
         expect_instr(op, w);
         if (i == 39) run = 1'b0;
      end
      wait_state(3'd0, 40, "idle after run");
      check("queue empty", 32'(sb.size()), 32'd0);
      check("retired total", retired, ret_view(32'd40));

      // Reset asserted during MEM
      opcode   = 6'h23;
      cur_wait = 255;
      expect_instr(6'h23, 0);
      run = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.mem_req) break;
      end
      check("in MEM", state, 3'd4);
      #2 rstd = 1'b0;
      #1;
      check("mrst state", state, 3'd0);
      check("mrst mem_req", bus.mem_req, 1'b0);
      check("mrst mem_wr", bus.mem_wr, 1'b0);
      check("mrst pc_we", pc_we, 1'b0);
      check("mrst reg_we", reg_we, 1'b0);
      check("mrst ir_we", ir_we, 1'b0);
      check("mrst retired", retired, 32'd0);
      check("mrst bus_err", bus_err, 1'b0);
      run = 1'b0;
      do_reset();
      @(negedge clk);
      check("post rst state", state, 3'd0);
      check("post rst retired", retired, 32'd0);

      // Single step of a branch, with an ignored second step mid-instruction
      opcode   = 6'h04;
      cur_wait = 0;
      base     = n_if;
      expect_instr(6'h04, 0);
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      repeat (6) @(negedge clk);
      check("step state", state, 3'd0);
      check("step fetches", 32'(n_if - base), 32'd1);
      check("step queue", 32'(sb.size()), 32'd0);
      check("step retired", retired, ret_view(32'd1));

      // halt_req raised during EX of an ALU op
      opcode = 6'h00;
      expect_instr(6'h00, 0);
      run = 1'b1;
      wait_ir("halt ir_we");
      @(posedge clk);
      @(posedge clk);
      #1 halt_req = 1'b1;
      wait_state(3'd6, 10, "halt entered");
      run = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (state != 3'd6) cnt++;
      end
      check("halt sticky", 32'(cnt), 32'd0);
      check("halt queue", 32'(sb.size()), 32'd0);
      check("halt retired", retired, ret_view(32'd2));
      rstd = 1'b0;
      #1;
      check("halt rst state", state, 3'd0);
      halt_req = 1'b0;
      do_reset();

      // SW with no ready: watchdog timeout
      opcode   = 6'h2B;
      cur_wait = 255;
      base     = n_pc;
      run      = 1'b1;
      cnt      = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.mem_req && bus.mem_wr) cnt++;
      end
      check("wd req cycles", 32'(cnt), 32'(TO));
      check("wd bus_err", bus_err, 1'b1);
      check("wd state", state, 3'd6);
      check("wd pc_we count", 32'(n_pc - base), 32'd0);
      check("wd retired", retired, 32'd0);
      run = 1'b0;
      do_reset();
      @(negedge clk);
      check("wd cleared", bus_err, 1'b0);

      // HLT opcode: IF, ID, then HALT
      opcode = 6'h3F;
      base   = n_pc;
      run    = 1'b1;
      wait_ir("hlt ir_we");
      w = cyc;
      wait_state(3'd6, 10, "hlt halt");
      check("hlt cycles", 32'(cyc - w), 32'd2);
      check("hlt pc_we count", 32'(n_pc - base), 32'd0);
      check("hlt retired", retired, 32'd0);
      run = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cycle_ctrl.md
# cycle_ctrl

Multi-cycle instruction sequencer for the processor core. It replaces single-cycle free-running PC update with a state machine that drives the PC write, instruction-register load, data-memory request and register-file write enables. Data memory is accessed through a req/ready handshake, guarded by a watchdog. It sits beside the execute and writeback stages, takes the opcode field of the fetched instruction, and gates every architectural state update in the core.

## Interface
- TIMEOUT, default 16: maximum cycles `mem_req` may wait for `mem_ready` before a bus error (legal range 1..255).
- clk  input  1  clock; all state updates on posedge.
- rstd  input  1  reset, asynchronous, active-low.
- run  input  1  level; 1 = continuous execution, 0 = stop at the next instruction boundary.
- step  input  1  single-cycle pulse; executes exactly one instruction from IDLE.
- halt_req  input  1  level; sampled only at instruction boundaries.
- opcode  input  6  ins[31:26] of the current instruction register.
- mem_ready  input  1  data memory completion strobe.
- ir_we  output  1  load instruction register.
- pc_we  output  1  load PC with nextpc (exactly one pulse per retired instruction).
- reg_we  output  1  register-file write enable.
- mem_req  output  1  data memory request.
- mem_wr  output  1  1 = store, valid while mem_req = 1.
- state  output  3  current state encoding.
- bus_err  output  1  sticky watchdog error flag.
- retired  output  32  retired-instruction count.

## Operation
- States and encodings: IDLE = 0, IF = 1, ID = 2, EX = 3, MEM = 4, WB = 5, HALT = 6. Encoding 7 is unreachable; if reached, the next state is IDLE.
- Opcode classes:
  - LW = 6'h23.
  - SW = 6'h2B.
  - BR = 6'h04 or 6'h05.
  - J = 6'h02 or 6'h03.
  - HLT = 6'h3F.
  - All other opcodes are ALU (including R-type 6'h00).
- IDLE: if run = 1 or step = 1, go to IF; otherwise stay.
- IF: ir_we = 1; go to ID.
- ID: opcode HLT goes to HALT with no pc_we; any other opcode goes to EX.
- EX:
  - LW or SW goes to MEM.
  - BR or J: pc_we = 1, then boundary.
  - ALU goes to WB.
- MEM:
  - mem_req = 1; mem_wr = 1 for SW.
  - On mem_ready = 1: LW goes to WB; SW asserts pc_we = 1 in that cycle, then boundary.
  - Watchdog counter clears on MEM entry and increments each MEM cycle without mem_ready. When the counter reaches TIMEOUT, set bus_err and go to HALT with no pc_we and no reg_we.
- WB: reg_we = 1, pc_we = 1, then boundary.
- Boundary (the next state after an instruction retires):
  - halt_req = 1 goes to HALT.
  - Otherwise, run = 1 goes to IF.
  - Otherwise, go to IDLE.
  - A step that started the instruction therefore always returns to IDLE when run = 0.
- HALT: all enables are 0. Only reset exits HALT.
- All enables are decoded from state (plus mem_ready in MEM). Enables are 0 in IDLE and HALT.
- bus_err stays set until reset.

## Timing
- Reset values: state = IDLE, all enables 0, bus_err = 0, retired = 0, watchdog = 0. Reset is asynchronous; all of these are asserted immediately on rstd falling, including mid-instruction. A partially executed instruction is abandoned with no pc_we.
- Cycles per instruction, counted from IF:
  - ALU: 4.
  - LW: 5 + wait cycles.
  - SW: 4 + wait cycles.
  - BR/J: 3.
  - HLT: 2, then HALT.
- mem_ready outside MEM is ignored.
- mem_ready arriving in the first MEM cycle means zero wait cycles.
- mem_ready in the same cycle the watchdog reaches TIMEOUT: the ready wins, with no error.
- step and run asserted together: treated as run.
- step while not in IDLE: ignored.
- halt_req asserted mid-instruction: the instruction completes, then HALT.
- retired increments in the cycle pc_we = 1 and is visible the next cycle. It wraps from 32'hFFFFFFFF to 0.

## Configuration
- CYCLE_CTRL_PERF_EN defined: the retired counter is implemented as described.
- CYCLE_CTRL_PERF_EN undefined: no counter registers are built and retired is constant 0. All other behaviour is identical.

## Test plan
- Reset, then run = 1 with opcode 6'h00 held: state sequence is 1,2,3,5,1,…; pc_we pulses every 4 cycles; reg_we coincides with pc_we; retired = 3 after 12 cycles.
- LW (6'h23) with mem_ready after 2 wait cycles: mem_req high for 3 cycles; then WB; pc_we occurs on cycle 7 counted from IF.
- SW (6'h2B) with mem_ready never asserted, TIMEOUT = 4: mem_req/mem_wr are high for 4 cycles, then bus_err = 1, state = 6, pc_we never asserted, retired unchanged.
- run = 0 with a single step pulse and opcode 6'h04: sequence IF, ID, EX(pc_we), IDLE; retired = 1; a second step pulse in the middle of the instruction is ignored.
- halt_req = 1 during EX of an ALU op: WB completes (retired + 1), then state = 6 and stays there until rstd = 0.
- rstd pulled low in MEM: all outputs are 0 immediately; after release, state = 0 and retired = 0 (0 also when CYCLE_CTRL_PERF_EN is undefined).
